pico_core_gen2: RTL and testbench
=================================

PICO_CORE_GEN2 -- requirements
Module: pico_core_gen2

Interface
REQ-001 Parameter XLEN, default 8: register/ALU data width; power of two, 8..32.
REQ-002 Parameter IQ_DEPTH, default 4: instruction-queue depth in 16-bit entries; power of two, >= 2.
REQ-003 Parameter PC_W, default 8: program-counter width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ld_valid  in  1  loader byte valid.
REQ-007 ld_data  in  8  loader byte, low byte first, then high byte.
REQ-008 ld_ready  out  1  loader may transfer a byte.
REQ-009 flush  in  1  synchronous queue/loader clear.
REQ-010 res_valid  out  1  one-cycle pulse: register write-back occurred.
REQ-011 res_rd  out  3  destination index of the last write-back.
REQ-012 res_data  out  XLEN  value written by the last write-back.
REQ-013 st_valid  out  1  one-cycle pulse: store executed.
REQ-014 st_data  out  XLEN  registers[rs2] of the last store.
REQ-015 br_taken  out  1  last executed branch taken.
REQ-016 pc  out  PC_W  program counter.
REQ-017 iq_count  out  clog2(IQ_DEPTH)+1  queue occupancy.
REQ-018 busy  out  1  core in EXEC or queue non-empty.

Function
REQ-019 Encoding: opcode[1:0], rd[4:2], rs1[7:5], rs2[10:8], imm[12:8], funct3[15:13]; 8 registers, r0 reads 0, writes to r0 discarded (no res_valid).
REQ-020 Byte transfer when ld_valid & ld_ready; ld_ready = !full; phase bit toggles per transfer; the high-byte transfer pushes {high,low} into the queue.
REQ-021 Simultaneous push and pop: both occur, iq_count unchanged; full queue: ld_ready=0 for both phases, held low byte retained.
REQ-022 FSM IDLE->EXEC when queue non-empty (pop into IR on that edge); EXEC->IDLE next edge; one instruction per 2 cycles max.
REQ-023 EXEC edge commits write-back, pc, st/res outputs; res_valid/st_valid high exactly the following cycle.
REQ-024 R-type (00) funct3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLTU; shift amount = rs2 value low clog2(XLEN) bits; arithmetic mod 2^XLEN.
REQ-025 I-type (01): funct3=000 ADDI rs1+zext(imm); else LI zext(imm).
REQ-026 S-type (10): st_data<=registers[rs2], st_valid pulse, no register write.
REQ-027 B-type (11) funct3[1:0]: 00 EQ, 01 NE, 10 LTU, 11 GEU; condition evaluated in the EXEC cycle from current operands (no stale flag); taken: pc+=sext(imm), else pc+=1; br_taken updated.
REQ-028 Non-branch: pc+=1; br_taken<=0; pc wraps mod 2^PC_W.
REQ-029 flush: empties queue, clears loader phase; an instruction in EXEC completes; flush has priority over a same-cycle push.

Reset
REQ-030 rst asserted: registers, pc, IR, queue pointers, phase, iq_count, res_*, st_*, br_taken, busy all 0; FSM IDLE; ld_ready=1 next after release.
REQ-031 Reset mid-load or mid-EXEC discards the partial instruction; no write-back occurs.

Verification
REQ-032 Load 0x2505 (LI r1,5), 0x2709 (LI r2,7), 0x022C (ADD r3,r1,r2) -> res pulses rd=1/5, rd=2/7, rd=3/12; pc=3.
REQ-033 Then 0x1E03 (BEQ r0,r6,-2) -> br_taken=1, pc=1, no res_valid.
REQ-034 LI r1,31 then SUB r2,r0,r1 (funct3 001) -> res_data = 2^XLEN-31 (XLEN=8: 0xE1).
REQ-035 Hold core off-queue, push IQ_DEPTH instructions -> iq_count=IQ_DEPTH, ld_ready=0; single pop -> ld_ready=1; push+pop same cycle -> count constant.
REQ-036 Send low byte only, then flush -> iq_count=0; next byte treated as low byte.
REQ-037 Assert rst during EXEC of LI r4,9 -> r4=0, res_valid never pulses, pc=0.

Source files
------------

// File: rtl/pico_core_gen2.sv
// pico_core_gen2: byte-loaded 16-bit instruction queue feeding a two-cycle
// IDLE/EXEC micro-core with 8 x XLEN registers, ALU, store and branch units.
module pico_core_gen2 #(
   parameter int unsigned XLEN     = 8,
   parameter int unsigned IQ_DEPTH = 4,
   parameter int unsigned PC_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_valid,
   input  logic [7:0]                   ld_data,
   output logic                         ld_ready,
   input  logic                         flush,
   output logic                         res_valid,
   output logic [2:0]                   res_rd,
   output logic [XLEN-1:0]              res_data,
   output logic                         st_valid,
   output logic [XLEN-1:0]              st_data,
   output logic                         br_taken,
   output logic [PC_W-1:0]              pc,
   output logic [$clog2(IQ_DEPTH):0]    iq_count,
   output logic                         busy
);

   localparam int unsigned AW  = $clog2(IQ_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned SHW = $clog2(XLEN);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EXEC = 1'b1;

   localparam logic [1:0] OP_R = 2'b00;
   localparam logic [1:0] OP_I = 2'b01;
   localparam logic [1:0] OP_S = 2'b10;
   localparam logic [1:0] OP_B = 2'b11;

   logic [0:0]      state, state_nxt;
   logic [15:0]     iq_mem [IQ_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_nxt;
   logic            phase;
   logic [7:0]      low_byte;
   logic [15:0]     ir;
   logic [XLEN-1:0] regs [8];

   logic push, pop;

   // Decoded fields of the instruction currently in EXEC
   logic [1:0]        opcode;
   logic [2:0]        rd, rs1, rs2, funct3;
   logic [4:0]        imm;
   logic signed [4:0] imm_s;
   logic [XLEN-1:0]   rs1_v, rs2_v, alu_v, wb_v;
   logic              wb_en, br_cond;
   logic [PC_W-1:0]   br_off;

   assign opcode = ir[1:0];
   assign rd     = ir[4:2];
   assign rs1    = ir[7:5];
   assign rs2    = ir[10:8];
   assign imm    = ir[12:8];
   assign funct3 = ir[15:13];
   assign imm_s  = imm;
   assign br_off = PC_W'(imm_s);
   assign rs1_v  = regs[rs1];
   assign rs2_v  = regs[rs2];

   // Loader handshake and queue traffic; flush wins over push and pop
   assign push = ld_valid && ld_ready && phase && !flush;
   assign pop  = (state == IDLE) && (iq_count != '0) && !flush;

   always_comb begin
      count_nxt = iq_count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = iq_count + CW'(1);
            2'b01:   count_nxt = iq_count - CW'(1);
            default: count_nxt = iq_count;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = EXEC;
         EXEC:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_v = '0;
      case (funct3)
         3'd0:    alu_v = rs1_v + rs2_v;
         3'd1:    alu_v = rs1_v - rs2_v;
         3'd2:    alu_v = rs1_v & rs2_v;
         3'd3:    alu_v = rs1_v | rs2_v;
         3'd4:    alu_v = rs1_v ^ rs2_v;
         3'd5:    alu_v = rs1_v << rs2_v[SHW-1:0];
         3'd6:    alu_v = rs1_v >> rs2_v[SHW-1:0];
         default: alu_v = XLEN'(rs1_v < rs2_v);
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (funct3[1:0])
         2'b00:   br_cond = (rs1_v == rs2_v);
         2'b01:   br_cond = (rs1_v != rs2_v);
         2'b10:   br_cond = (rs1_v <  rs2_v);
         default: br_cond = (rs1_v >= rs2_v);
      endcase
   end

   always_comb begin
      wb_v  = '0;
      wb_en = 1'b0;
      case (opcode)
         OP_R: begin
            wb_v  = alu_v;
            wb_en = (rd != 3'd0);
         end
         OP_I: begin
            wb_v  = (funct3 == 3'd0) ? rs1_v + XLEN'(imm) : XLEN'(imm);
            wb_en = (rd != 3'd0);
         end
         default: begin
            wb_v  = '0;
            wb_en = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Queue storage carries no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) iq_mem[wr_ptr] <= {ld_data, low_byte};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         iq_count  <= '0;
         phase     <= 1'b0;
         low_byte  <= '0;
         ld_ready  <= 1'b1;
         busy      <= 1'b0;
         ir        <= '0;
         pc        <= '0;
         res_valid <= 1'b0;
         res_rd    <= '0;
         res_data  <= '0;
         st_valid  <= 1'b0;
         st_data   <= '0;
         br_taken  <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         iq_count <= count_nxt;
         ld_ready <= (count_nxt != CW'(IQ_DEPTH));
         busy     <= (state_nxt == EXEC) || (count_nxt != '0);

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            phase  <= 1'b0;
         end else begin
            if (ld_valid && ld_ready) begin
               phase <= !phase;
               if (!phase) low_byte <= ld_data;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
               ir     <= iq_mem[rd_ptr];
            end
         end

         res_valid <= 1'b0;
         st_valid  <= 1'b0;
         if (state == EXEC) begin
            if (wb_en) begin
               regs[rd]  <= wb_v;
               res_valid <= 1'b1;
               res_rd    <= rd;
               res_data  <= wb_v;
            end
            if (opcode == OP_S) begin
               st_valid <= 1'b1;
               st_data  <= rs2_v;
            end
            if (opcode == OP_B && br_cond) begin
               pc       <= pc + br_off;
               br_taken <= 1'b1;
            end else begin
               pc       <= pc + PC_W'(1);
               br_taken <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pico_core_gen2.sv
// Scoreboard bench for pico_core_gen2: directed programs with hand-computed
// write-back/store values, plus queue occupancy, flush and reset checks.
module tb_pico_core_gen2;

   localparam int unsigned XLEN = 8;
   localparam int unsigned IQD  = 4;
   localparam int unsigned PCW  = 8;

   typedef struct packed {
      logic [2:0]      rd;
      logic [XLEN-1:0] data;
   } res_t;

   logic            clk, rst, ld_valid, flush;
   logic [7:0]      ld_data;
   logic            ld_ready, res_valid, st_valid, br_taken, busy;
   logic [2:0]      res_rd;
   logic [XLEN-1:0] res_data, st_data;
   logic [PCW-1:0]  pc;
   logic [$clog2(IQD):0] iq_count;

   int total = 0;
   int bad   = 0;
   res_t            exp_res [$];
   logic [XLEN-1:0] exp_st  [$];

   pico_core_gen2 #(.XLEN(XLEN), .IQ_DEPTH(IQD), .PC_W(PCW)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .flush(flush), .res_valid(res_valid),
      .res_rd(res_rd), .res_data(res_data), .st_valid(st_valid),
      .st_data(st_data), .br_taken(br_taken), .pc(pc),
      .iq_count(iq_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every result/store pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid) begin
            if (exp_res.size() == 0) begin
               chk("unexpected_res_valid", 32'(res_rd), 32'hFFFF_FFFF);
            end else begin
               res_t e;
               e = exp_res.pop_front();
               chk("res_rd", 32'(res_rd), 32'(e.rd));
               chk("res_data", 32'(res_data), 32'(e.data));
            end
         end
         if (st_valid) begin
            if (exp_st.size() == 0) begin
               chk("unexpected_st_valid", 32'(st_data), 32'hFFFF_FFFF);
            end else begin
               logic [XLEN-1:0] s;
               s = exp_st.pop_front();
               chk("st_data", 32'(st_data), 32'(s));
            end
         end
      end
   end

   // Called just after a falling edge; returns one falling edge after the transfer
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!ld_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ld_ready) chk("ld_ready_timeout", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_data  = b;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic send_instr(input logic [15:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
   endtask

   task automatic exp_wb(input logic [2:0] rd, input logic [XLEN-1:0] d);
      res_t e;
      e.rd   = rd;
      e.data = d;
      exp_res.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("busy_timeout", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; ld_valid = 1'b0; ld_data = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_iq_count", 32'(iq_count), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_st_valid", 32'(st_valid), 32'd0);
      chk("rst_br_taken", 32'(br_taken), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ld_ready_after_rst", 32'(ld_ready), 32'd1);

      // LI r1,5 ; LI r2,7 ; ADD r3,r1,r2
      exp_wb(3'd1, 8'd5); exp_wb(3'd2, 8'd7); exp_wb(3'd3, 8'd12);
      send_instr(16'h2505); send_instr(16'h2709); send_instr(16'h022C);
      wait_idle();
      chk("pc_after_add", 32'(pc), 32'd3);

      // BEQ r0,r6,-2 taken from pc 3
      send_instr(16'h1E03);
      wait_idle();
      chk("beq_taken", 32'(br_taken), 32'd1);
      chk("pc_after_beq", 32'(pc), 32'd1);

      // LI r1,31 ; SUB r2,r0,r1
      exp_wb(3'd1, 8'd31); exp_wb(3'd2, 8'hE1);
      send_instr(16'h3F05); send_instr(16'h2108);
      wait_idle();
      chk("br_cleared", 32'(br_taken), 32'd0);
      chk("pc_after_sub", 32'(pc), 32'd3);

      // r1=31 r2=E1 r3=12: AND OR XOR SLL SRL SLTU ADDI, store r7, write to r0
      exp_wb(3'd4, 8'h0C); send_instr(16'h4330);
      exp_wb(3'd5, 8'hFF); send_instr(16'h6234);
      exp_wb(3'd6, 8'hED); send_instr(16'h8358);
      exp_wb(3'd7, 8'h80); send_instr(16'hA67C);
      exp_wb(3'd4, 8'h0E); send_instr(16'hC350);
      exp_wb(3'd5, 8'h01); send_instr(16'hE174);
      exp_wb(3'd6, 8'h22); send_instr(16'h0339);
      exp_st.push_back(8'h80); send_instr(16'h0702);
      send_instr(16'h2501);
      wait_idle();
      chk("pc_after_alu", 32'(pc), 32'd12);

      // BLTU r1,r0 not taken; BNE r1,r2,+2 taken
      send_instr(16'h4023);
      wait_idle();
      chk("bltu_not_taken", 32'(br_taken), 32'd0);
      chk("pc_after_bltu", 32'(pc), 32'd13);
      send_instr(16'h2223);
      wait_idle();
      chk("bne_taken", 32'(br_taken), 32'd1);
      chk("pc_after_bne", 32'(pc), 32'd15);

      // Fill the queue with the core held in EXEC on a harmless no-op IR
      send_instr(16'h0000);
      wait_idle();
      force dut.state = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         exp_wb(3'd1, 8'(k));
         send_instr(16'(16'h2005 | (k << 8)));
      end
      chk("iq_full_count", 32'(iq_count), 32'(IQD));
      chk("iq_full_ld_ready", 32'(ld_ready), 32'd0);
      release dut.state;
      begin
         int n = 0;
         while (iq_count != 3'(IQD - 1) && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      chk("after_pop_count", 32'(iq_count), 32'(IQD - 1));
      chk("after_pop_ld_ready", 32'(ld_ready), 32'd1);
      exp_wb(3'd1, 8'd5);
      send_instr(16'h2505);
      chk("push_pop_count", 32'(iq_count), 32'(IQD - 1));
      wait_idle();

      // Lone low byte then flush: loader phase must restart at the low byte
      send_byte(8'hAA);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_count", 32'(iq_count), 32'd0);
      exp_wb(3'd3, 8'd9);
      send_instr(16'h290D);
      wait_idle();

      // Reset while LI r4,9 is in EXEC: no write-back, r4 cleared
      send_instr(16'h2911);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_exec_pc", 32'(pc), 32'd0);
      chk("rst_exec_count", 32'(iq_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      exp_st.push_back(8'h00);
      send_instr(16'h0402);
      wait_idle();
      chk("pc_after_rst_store", 32'(pc), 32'd1);

      chk("res_queue_drained", 32'(exp_res.size()), 32'd0);
      chk("st_queue_drained", 32'(exp_st.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
